muldiv_ctrl: RTL and testbench

- Iterative multiply/divide sequencer for the EX stage of the pipelined MIPS core.
- Owns the HI/LO registers and sequences one shared WIDTH-bit add/sub datapath over WIDTH+1 cycles for MULT/MULTU/DIV/DIVU.
- Issues stall requests to the hazard unit whenever a HI/LO-touching instruction meets a busy unit.
- Serves MFHI/MFLO/MTHI/MTLO.

---
 rtl/muldiv_ctrl_pkg.sv | 33 +++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Holds the R-type funct codes, the sequencer state encoding and the default datapath width.
package muldiv_ctrl_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } state_e;

  // True for the four ops that occupy the iterative datapath
  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  // True for every op that touches HI/LO and therefore must wait on a busy unit
  function automatic logic is_hilo(input logic [5:0] f);
    return is_muldiv(f) || (f == F_MFHI) || (f == F_MTHI) ||
           (f == F_MFLO) || (f == F_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath on the {acc, shreg} pair.
// Multiply: conditionally add the multiplicand, then shift the pair right by one.
// Divide: shift the pair left by one, trial-subtract the divisor, restore on borrow.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] shreg_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] shreg_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] shl_s;
  logic [WIDTH:0] sub_s;
  logic           ge_s;

  // Single add-or-pass / trial-subtract step
  always_comb begin
    sum_s = {1'b0, acc_i} + (shreg_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    shl_s = {acc_i, shreg_i[WIDTH-1]};
    sub_s = shl_s - {1'b0, opnd_i};
    ge_s  = (shl_s >= {1'b0, opnd_i});
    if (is_div_i) begin
      acc_o   = ge_s ? WIDTH'(sub_s) : shl_s[WIDTH-1:0];
      shreg_o = {shreg_i[WIDTH-2:0], ge_s};
    end else begin
      acc_o   = sum_s[WIDTH:1];
      shreg_o = {sum_s[0], shreg_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage.
// Runs MULT/MULTU/DIV/DIVU over one shared add/sub step, serves MFHI/MFLO/MTHI/MTLO,
// and requests a pipeline stall whenever a HI/LO op meets a busy unit.
// Optional build macro MULDIV_EARLY_TERM_EN: multiply finishes as soon as the
// remaining multiplier bits are zero (divide latency is unaffected).
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall_o,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   shamt_q;
  logic [WIDTH-1:0]   acc_q, shreg_q, opnd_q, a_raw_q;
  logic               is_div_q, sa_q, sb_q, dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;

  logic               sgn_s, div_s, sa_s, sb_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s;
  logic [WIDTH-1:0]   step_acc_d, step_shreg_d;
  logic               early_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   res_hi_d, res_lo_d, rd_data_d;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .shreg_i  (shreg_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc_d),
    .shreg_o  (step_shreg_d)
  );

  // Operand decode at acceptance: signedness and absolute values
  always_comb begin
    sgn_s   = (func == F_MULT) || (func == F_DIV);
    div_s   = (func == F_DIV) || (func == F_DIVU);
    sa_s    = sgn_s & op_a[WIDTH-1];
    sb_s    = sgn_s & op_b[WIDTH-1];
    abs_a_s = sa_s ? (~op_a + {{(WIDTH-1){1'b0}}, 1'b1}) : op_a;
    abs_b_s = sb_s ? (~op_b + {{(WIDTH-1){1'b0}}, 1'b1}) : op_b;
  end

  // Early-exit detection: remaining multiplier bits after this step are all zero
  always_comb begin
`ifdef MULDIV_EARLY_TERM_EN
    early_s = !is_div_q &&
              ((step_shreg_d & ({WIDTH{1'b1}} >> (cnt_q + CNT_W'(1)))) == {WIDTH{1'b0}});
`else
    early_s = 1'b0;
`endif
  end

  // Sign correction and result mapping applied in FIXUP
  always_comb begin
    prod_s   = {acc_q, shreg_q} >> shamt_q;
    res_hi_d = {WIDTH{1'b0}};
    res_lo_d = {WIDTH{1'b0}};
    if (!is_div_q) begin
      if (sa_q ^ sb_q) begin
        {res_hi_d, res_lo_d} = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
      end else begin
        {res_hi_d, res_lo_d} = prod_s;
      end
    end else if (dz_q) begin
      res_lo_d = {WIDTH{1'b1}};
      res_hi_d = a_raw_q;
    end else begin
      res_lo_d = (sa_q ^ sb_q) ? (~shreg_q + {{(WIDTH-1){1'b0}}, 1'b1}) : shreg_q;
      res_hi_d = sa_q ? (~acc_q + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_q;
    end
  end

  // MFHI/MFLO read port, only live while the unit is idle
  always_comb begin
    rd_data_d = {WIDTH{1'b0}};
    if (req_valid && (state_q == ST_IDLE)) begin
      case (func)
        F_MFHI:  rd_data_d = hi_q;
        F_MFLO:  rd_data_d = lo_q;
        default: rd_data_d = {WIDTH{1'b0}};
      endcase
    end else begin
      rd_data_d = {WIDTH{1'b0}};
    end
  end

  // Sequencer FSM with HI/LO ownership and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      shamt_q  <= {CNT_W{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      shreg_q  <= {WIDTH{1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      a_raw_q  <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid && !flush) begin
            if (is_muldiv(func)) begin
              state_q  <= ST_CALC;
              busy_q   <= 1'b1;
              cnt_q    <= {CNT_W{1'b0}};
              shamt_q  <= {CNT_W{1'b0}};
              acc_q    <= {WIDTH{1'b0}};
              shreg_q  <= div_s ? abs_a_s : abs_b_s;
              opnd_q   <= div_s ? abs_b_s : abs_a_s;
              a_raw_q  <= op_a;
              is_div_q <= div_s;
              sa_q     <= sa_s;
              sb_q     <= sb_s;
              dz_q     <= div_s && (op_b == {WIDTH{1'b0}});
            end else if (func == F_MTHI) begin
              hi_q <= op_a;
            end else if (func == F_MTLO) begin
              lo_q <= op_a;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q   <= step_acc_d;
            shreg_q <= step_shreg_d;
            cnt_q   <= cnt_q + CNT_W'(1);
            shamt_q <= CNT_W'(WIDTH - 1) - cnt_q;
            if ((cnt_q == CNT_W'(WIDTH - 1)) || early_s) begin
              state_q <= ST_FIXUP;
            end
          end
        end
        ST_FIXUP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (!flush) begin
            hi_q   <= res_hi_d;
            lo_q   <= res_lo_d;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign stall_o = req_valid & busy_q & is_hilo(func);
  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = rd_data_d;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (32-bit build).
module tb_muldiv_ctrl;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [5:0]  func = 6'b000000;
  logic [31:0] op_a = 32'h0;
  logic [31:0] op_b = 32'h0;
  logic        flush = 1'b0;
  logic        stall_o, busy, done;
  logic [31:0] rd_data, hi, lo;

  int errors = 0;
  int checks = 0;

  muldiv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .func      (func),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .stall_o   (stall_o),
    .busy      (busy),
    .done      (done),
    .rd_data   (rd_data),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    func = f;
    op_a = a;
    op_b = b;
    tick();
    req_valid = 1'b0;
    func = 6'b000000;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Runs n cycles and reports whether done was ever seen high
  task automatic watch_done(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    int n;
    logic seen;
    logic stall_hold;

    // Reset state
    @(negedge clk);
    tick();
    tick();
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_stall", {31'h0, stall_o}, 32'h0);
    rst = 1'b0;
    tick();

    // mult 7 * -3
    issue(F_MULT, 32'h00000007, 32'hFFFFFFFD);
    check("mult_busy", {31'h0, busy}, 32'h1);
    wait_done(n);
`ifdef MULDIV_EARLY_TERM_EN
    check("mult_latency", n, 32'd3);
`else
    check("mult_latency", n, 32'd33);
`endif
    check("mult_done", {31'h0, done}, 32'h1);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFEB);
    check("mult_busy_end", {31'h0, busy}, 32'h0);
    tick();
    check("mult_done_pulse", {31'h0, done}, 32'h0);

    // multu 0xFFFFFFFF * 2
    issue(F_MULTU, 32'hFFFFFFFF, 32'h00000002);
    wait_done(n);
    check("multu_hi", hi, 32'h00000001);
    check("multu_lo", lo, 32'hFFFFFFFE);

    // mult -1 * -1
    issue(F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n);
    check("mult_nn_hi", hi, 32'h00000000);
    check("mult_nn_lo", lo, 32'h00000001);

    // div -7 / 2 (fixed latency in every build)
    issue(F_DIV, 32'hFFFFFFF9, 32'h00000002);
    wait_done(n);
    check("div_latency", n, 32'd33);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    // divu by zero
    issue(F_DIVU, 32'h12345678, 32'h00000000);
    wait_done(n);
    check("divz_latency", n, 32'd33);
    check("divz_lo", lo, 32'hFFFFFFFF);
    check("divz_hi", hi, 32'h12345678);

    // mthi then mfhi next cycle; mtlo then mflo
    issue(F_MTHI, 32'hA5A5A5A5, 32'h0);
    req_valid = 1'b1;
    func = F_MFHI;
    #1;
    check("mfhi_rd", rd_data, 32'hA5A5A5A5);
    check("mfhi_stall", {31'h0, stall_o}, 32'h0);
    req_valid = 1'b0;
    #1;
    check("rd_idle_zero", rd_data, 32'h0);
    tick();
    issue(F_MTLO, 32'h0BADF00D, 32'h0);
    req_valid = 1'b1;
    func = F_MFLO;
    #1;
    check("mflo_rd", rd_data, 32'h0BADF00D);
    req_valid = 1'b0;
    tick();

    // mult 3*5, then mflo held from 3 cycles after acceptance
    issue(F_MULT, 32'h00000003, 32'h00000005);
    tick();
    tick();
    req_valid = 1'b1;
    func = F_MFLO;
    #1;
    check("rd_stall", {31'h0, stall_o}, 32'h1);
    check("rd_busy_zero", rd_data, 32'h0);
    func = 6'b100000;
    #1;
    check("unk_no_stall", {31'h0, stall_o}, 32'h0);
    func = F_MFLO;
    #1;
    n = 0;
    stall_hold = 1'b1;
    while (done !== 1'b1 && n < 100) begin
      if (stall_o !== 1'b1) stall_hold = 1'b0;
      tick();
      #1;
      n++;
    end
    check("rd_stall_held", {31'h0, stall_hold}, 32'h1);
    check("rd_done_seen", {31'h0, done}, 32'h1);
    check("rd_stall_idle", {31'h0, stall_o}, 32'h0);
    check("rd_new_lo", rd_data, 32'h0000000F);
    req_valid = 1'b0;
    func = 6'b000000;
    tick();

    // div 100/7 flushed at CALC iteration 10
    issue(F_MTHI, 32'h13579BDF, 32'h0);
    issue(F_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {31'h0, busy}, 32'h0);
    check("flush_done", {31'h0, done}, 32'h0);
    watch_done(40, seen);
    check("flush_no_done", {31'h0, seen}, 32'h0);
    check("flush_hi", hi, 32'h13579BDF);
    check("flush_lo", lo, 32'h0000000F);

    // div 100/7 complete
    issue(F_DIV, 32'd100, 32'd7);
    wait_done(n);
    check("div100_lo", lo, 32'd14);
    check("div100_hi", hi, 32'd2);

    // flush arriving in the FIXUP cycle wins
    issue(F_DIVU, 32'd50, 32'd3);
    for (int i = 0; i < 32; i++) tick();
    check("fixup_busy", {31'h0, busy}, 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fixup_flush_done", {31'h0, done}, 32'h0);
    check("fixup_flush_busy", {31'h0, busy}, 32'h0);
    check("fixup_flush_hi", hi, 32'd2);
    check("fixup_flush_lo", lo, 32'd14);

    // flush in IDLE blocks acceptance
    req_valid = 1'b1;
    func = F_MULT;
    op_a = 32'd4;
    op_b = 32'd4;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    check("idle_flush_busy", {31'h0, busy}, 32'h0);

    // unrecognised func ignored
    issue(6'b100001, 32'd4, 32'd4);
    check("unk_busy", {31'h0, busy}, 32'h0);

    // reset mid-CALC
    issue(F_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstcalc_hi", hi, 32'h0);
    check("rstcalc_lo", lo, 32'h0);
    check("rstcalc_busy", {31'h0, busy}, 32'h0);
    watch_done(40, seen);
    check("rstcalc_no_done", {31'h0, seen}, 32'h0);

`ifdef MULDIV_EARLY_TERM_EN
    // early termination: 9 * 1
    issue(F_MULT, 32'd9, 32'd1);
    wait_done(n);
    check("early_latency", n, 32'd2);
    check("early_lo", lo, 32'd9);
    check("early_hi", hi, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
